det_stream_ctrl: RTL

Sequencer for the single-bit "1011" pattern detector (det_1011).
- Accepts bytes over a valid/ready stream and feeds them to the detector MSB-first, one bit per clock.
- Captures the detector's match output per bit and returns a per-byte hit mask plus a running match count.
- The detector has no enable and advances every clock. Between bytes, this block resets the detector and replays the last 3 stream bits, so matches spanning byte boundaries are still found.

---
 rtl/det_stream_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/det_stream_ctrl.sv
// Stream sequencer for the serial "1011" detector: feeds each word MSB-first,
// replays the 3-bit history after resetting the detector, and reports a per-bit hit mask.
module det_stream_ctrl #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic              flush,
  input  logic              clr_cnt,
  output logic              det_rstn,
  output logic              det_in,
  input  logic              det_out,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_hits,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              busy
);

  localparam int BC_MAX = (DATA_W > 3) ? DATA_W : 3;
  localparam int BC_W   = $clog2(BC_MAX);
  localparam logic [BC_W-1:0] REPLAY_END = BC_W'(2);
  localparam logic [BC_W-1:0] SHIFT_END  = BC_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE, DRST, REPLAY, SHIFT, DRAIN, REPORT
  } state_t;

  state_t            state, state_nx;
  logic [2:0]        hist;
  logic [DATA_W-1:0] shreg;
  logic              last_q;
  logic [BC_W-1:0]   bit_cnt;
  logic              capture;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    // NOTE: registers update with <= so every flop samples pre-edge values.
    else     state <= state_nx;
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    state_nx = state;
    s_ready  = 1'b0;
    m_valid  = 1'b0;
    det_rstn = 1'b1;
    det_in   = 1'b0;
    capture  = 1'b0;
    case (state)
      IDLE: begin
        s_ready = !flush;
        if (!flush && s_valid) state_nx = DRST;
      end
      DRST: begin
        det_rstn = 1'b0;
        state_nx = REPLAY;
      end
      REPLAY: begin
        det_in = hist[2];
        if (bit_cnt == REPLAY_END) state_nx = SHIFT;
      end
      SHIFT: begin
        det_in  = shreg[DATA_W-1];
        capture = (bit_cnt != '0);
        if (bit_cnt == SHIFT_END) state_nx = DRAIN;
      end
      DRAIN: begin
        capture  = 1'b1;
        state_nx = REPORT;
      end
      REPORT: begin
        m_valid = 1'b1;
        if (m_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist    <= 3'b000;
      shreg   <= '0;
      last_q  <= 1'b0;
      m_hits  <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (flush) begin
            hist <= 3'b000;
          end else if (s_valid) begin
            shreg   <= s_data;
            last_q  <= s_last;
            m_hits  <= '0;
            bit_cnt <= '0;
          end
        end
        REPLAY: begin
          // Rotating leaves hist unchanged after the three replay cycles.
          hist    <= {hist[1:0], hist[2]};
          bit_cnt <= (bit_cnt == REPLAY_END) ? '0 : bit_cnt + BC_W'(1);
        end
        SHIFT: begin
          shreg   <= shreg << 1;
          hist    <= {hist[1:0], shreg[DATA_W-1]};
          bit_cnt <= (bit_cnt == SHIFT_END) ? '0 : bit_cnt + BC_W'(1);
        end
        REPORT: begin
          if (m_ready && last_q) hist <= 3'b000;
        end
        default: ;
      endcase
      // Hits arrive one cycle behind their bit; shifting in at the LSB lands
      // the first driven bit's result at the MSB.
      if (capture) m_hits <= (m_hits << 1) | DATA_W'(det_out);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          match_cnt <= '0;
    else if (clr_cnt)                                 match_cnt <= '0;
    else if (capture && det_out && (match_cnt != '1)) match_cnt <= match_cnt + CNT_W'(1);
  end

endmodule
